// File: rtl/wb_result_stage_pkg.sv
// Shared definitions for the writeback result stage: result-source codes,
// FSM state encoding and the latched instruction record.
package wb_result_stage_pkg;

    localparam int WB_XLEN = 32;

    localparam logic [1:0] RESULT_FROM_ALU = 2'b00;
    localparam logic [1:0] RESULT_FROM_MEM = 2'b01;
    localparam logic [1:0] RESULT_FROM_PC4 = 2'b10;
    localparam logic [1:0] RESULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [1:0]         src;
        logic               reg_write;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] alu_result;
        logic [WB_XLEN-1:0] pc_plus4;
    } wb_instr_t;

endpackage

// File: rtl/wb_result_stage_mux.sv
// Combinational 3:1 result select keyed on the ResultSource code; any code
// other than MEM/PC4 (including the illegal one) selects the ALU result.
module wb_result_mux
    import wb_result_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      src,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = alu_result;
        case (src)
            RESULT_FROM_MEM: result = mem_data;
            RESULT_FROM_PC4: result = pc_plus4;
            default:         result = alu_result;
        endcase
    end

endmodule

// File: rtl/wb_result_stage.sv
// Writeback stage: accepts one retiring instruction per handshake, waits on load
// data when needed, commits to the register file and counts retirements.
// Optional macro WB_ILLEGAL_SRC_TRAP_EN adds the illegal_src trap output.
module wb_result_stage
    import wb_result_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_result_src,
    input  logic             in_reg_write,
    input  logic [4:0]       in_rd,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             mem_rready,
`ifdef WB_ILLEGAL_SRC_TRAP_EN
    output logic             illegal_src,
`endif
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [CNT_W-1:0] retire_count
);

    wb_state_t        state_q, state_d;
    wb_instr_t        instr_q, instr_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             enter_commit;
    logic [1:0]       commit_src;
    logic             commit_reg_write;
    logic [4:0]       commit_rd;
    logic [XLEN-1:0]  mux_result;

    assign in_ready   = (state_q == IDLE) || (state_q == COMMIT);
    assign mem_rready = (state_q == WAIT_MEM);
    assign accept     = in_valid && in_ready;

    // While waiting on a load the committing instruction is the latched one;
    // otherwise the instruction being accepted this cycle commits next cycle.
    always_comb begin
        commit_src       = in_result_src;
        commit_reg_write = in_reg_write;
        commit_rd        = in_rd;
        if (state_q == WAIT_MEM) begin
            commit_src       = instr_q.src;
            commit_reg_write = instr_q.reg_write;
            commit_rd        = instr_q.rd;
        end
    end

    wb_result_mux #(.XLEN(XLEN)) u_mux (
        .src        (commit_src),
        .alu_result (in_alu_result),
        .mem_data   (mem_rdata),
        .pc_plus4   (in_pc_plus4),
        .result     (mux_result)
    );

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        retire_count_d = retire_count_q;
        illegal_d      = 1'b0;
        enter_commit   = 1'b0;

        case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (accept) begin
                    instr_d.src        = in_result_src;
                    instr_d.reg_write  = in_reg_write;
                    instr_d.rd         = in_rd;
                    instr_d.alu_result = in_alu_result;
                    instr_d.pc_plus4   = in_pc_plus4;
                    if (in_result_src == RESULT_FROM_MEM) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d      = COMMIT;
                        enter_commit = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d      = COMMIT;
                    enter_commit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commit outputs are registered on entry, so they are visible exactly
        // during the single COMMIT cycle.
        if (enter_commit) begin
            rf_waddr_d = commit_rd;
            rf_wdata_d = mux_result;
`ifdef WB_ILLEGAL_SRC_TRAP_EN
            if (commit_src == RESULT_ILLEGAL) begin
                illegal_d = 1'b1;
            end else begin
                rf_we_d        = commit_reg_write && (commit_rd != 5'd0);
                retire_count_d = retire_count_q + 1'b1;
            end
`else
            rf_we_d        = commit_reg_write && (commit_rd != 5'd0);
            retire_count_d = retire_count_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            instr_q        <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= 5'd0;
            rf_wdata_q     <= '0;
            retire_count_q <= '0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_count_q <= retire_count_d;
            illegal_q      <= illegal_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_count = retire_count_q;

`ifdef WB_ILLEGAL_SRC_TRAP_EN
    assign illegal_src = illegal_q;
`else
    logic unused_ok;
    assign unused_ok = illegal_q ^ (|instr_q.alu_result) ^ (|instr_q.pc_plus4);
`endif

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
- Writeback-stage consumer of the ResultSource encoding.
- Accepts one retiring instruction per handshake: ALU result, PC+4, destination register, and a 2-bit result-source code.
- For load results, waits on a variable-latency data-memory read response.
- Drives the register-file write port, one commit per instruction, and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of retire counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_result_src  in  2  RESULT_FROM_ALU=2'b00, RESULT_FROM_MEM=2'b01, RESULT_FROM_PC4=2'b10.
- in_reg_write  in  1  instruction writes rd.
- in_rd  in  5  destination register index.
- in_alu_result  in  XLEN  ALU result.
- in_pc_plus4  in  XLEN  PC+4 (link value).
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  load data.
- mem_rready  out  1  stage can take load data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- retire_count  out  CNT_W  instructions committed since reset.

Behaviour:
- Reset (synchronous, active-high): the following hold until the first cycle after reset deasserts.
  - state=IDLE.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - retire_count=0.
  - in_ready=1, mem_rready=0.
- FSM states: IDLE, WAIT_MEM, COMMIT.
- in_ready = (state==IDLE) || (state==COMMIT). mem_rready = (state==WAIT_MEM).
- Accept: when in_valid && in_ready, latch src, reg_write, rd, alu_result, pc_plus4.
  - src==ALU or PC4 -> COMMIT next cycle.
  - src==MEM -> WAIT_MEM.
- WAIT_MEM:
  - Holds until mem_rvalid=1. mem_rvalid is sampled only in WAIT_MEM; it is ignored in other states.
  - On mem_rvalid=1, latch mem_rdata and go to COMMIT next cycle.
  - No timeout; the stage stalls indefinitely.
- COMMIT: lasts exactly one cycle.
  - rf_we = reg_write && (rd!=0).
  - rf_waddr = rd.
  - rf_wdata: ALU->alu_result, MEM->captured load data, PC4->pc_plus4.
  - retire_count increments by 1 regardless of rf_we, wrapping modulo 2^CNT_W.
- Back-to-back: a new accept in COMMIT goes directly to COMMIT (ALU/PC4) or WAIT_MEM (MEM). Otherwise the stage returns to IDLE.
- Latency:
  - ALU/PC4: rf_we asserted 1 cycle after the accept cycle. Throughput 1 instr/cycle.
  - MEM: rf_we asserted 1 cycle after the mem_rvalid cycle.
- Outputs are registered. rf_we=0 in every non-COMMIT cycle. rf_waddr/rf_wdata hold their last value when rf_we=0.
- Illegal src 2'b11 (no macro): treated as ALU.
- Reset mid-operation (e.g. in WAIT_MEM): the pending instruction is discarded, with no write and no count. A late mem_rvalid after reset is ignored.

Optional Feature:
- Macro: WB_ILLEGAL_SRC_TRAP_EN.
- With the macro defined:
  - Adds output illegal_src (1 bit, reset 0).
  - src 2'b11 still reaches COMMIT, but rf_we is forced to 0, illegal_src pulses 1 for that cycle, and retire_count does not increment.
- Without the macro: the port is absent and 2'b11 behaves as ALU.

Decomposition:
- Shared package holds:
  - RESULT_FROM_ALU/MEM/PC4 constants, plus RESULT_ILLEGAL=2'b11.
  - FSM state enum wb_state_t.
  - A packed struct wb_instr_t {src, reg_write, rd, alu_result, pc_plus4}.
- One sub-module is natural: wb_result_mux, the combinational 3:1 select keyed on the package constants, reusable by forwarding logic.

Test Plan:
- ALU path: accept src=00, rd=5, alu=0x1234, reg_write=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234, retire_count=1.
- PC4 path: src=10, rd=1, pc_plus4=0x0000_0104 -> next cycle wdata=0x104. Then rd=0 -> rf_we=0 but retire_count still increments.
- Load with 3-cycle memory: accept src=01, rd=7; mem_rvalid=1 with rdata=0xDEADBEEF three cycles later -> in_ready=0 throughout WAIT_MEM; rf_we=1, wdata=0xDEADBEEF one cycle after rvalid.
- Back-to-back ALU stream: 4 instructions on consecutive cycles, in_valid constant -> 4 consecutive rf_we pulses, retire_count=4, no bubbles.
- Reset asserted in WAIT_MEM, then mem_rvalid=1 -> no write, retire_count=0, state IDLE.
- Macro on: src=11, rd=3 -> rf_we=0, illegal_src=1 for one cycle, count unchanged. Macro off: same stimulus -> writes alu_result to x3.
